// File: rtl/ftoi_wb_queue_if.sv
// ftoi writeback queue bus: issue credit, converter result, writeback.
// master = issuer/converter/writeback side, slave = the queue.
interface ftoi_wb_queue_if #(
  parameter int TAG_W = 5
);
  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic             cvt_valid;
  logic [31:0]      cvt_y;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ready;

  modport master (
    output issue_valid, issue_tag,
    output cvt_valid, cvt_y, wb_ready,
    input  issue_ready,
    input  wb_valid, wb_data, wb_tag
  );

  modport slave (
    input  issue_valid, issue_tag,
    input  cvt_valid, cvt_y, wb_ready,
    output issue_ready,
    output wb_valid, wb_data, wb_tag
  );
endinterface

// File: rtl/ftoi_wb_queue.sv
// ftoi writeback queue: tag pipe over converter latency, credit-gated FIFO.
// Ports: clk, rstn, bus (issue/cvt/wb), count, err. Option: FTOI_WB_DROP_X0_EN.
module ftoi_wb_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  ftoi_wb_queue_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [LAT-1:0]   tok_q;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [31:0]      dat_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic [31:0]      inflight;
  logic             accept;
  logic             tok_out;
  logic [TAG_W-1:0] tag_out;
  logic             match;
  logic             mismatch;
  logic             drop_x0;
  logic             want;
  logic             full;
  logic             pop;
  logic             ovf;
  logic             push;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++)
      inflight = inflight + {31'd0, tok_q[i]};
  end

  assign bus.issue_ready =
    ({{(32-CW){1'b0}}, count_q} + inflight) < DEPTH;

  assign accept  = bus.issue_valid && bus.issue_ready;
  assign tok_out = tok_q[LAT-1];
  assign tag_out = tag_q[LAT-1];

  // Token and converter valid must coincide; either one alone is
  // a protocol error and the token is simply retired.
  assign match    = tok_out && bus.cvt_valid;
  assign mismatch = tok_out ^ bus.cvt_valid;

`ifdef FTOI_WB_DROP_X0_EN
  assign drop_x0 = match && (tag_out == '0);
`else
  assign drop_x0 = 1'b0;
`endif

  assign full = count_q == CW'(DEPTH);
  assign pop  = bus.wb_valid && bus.wb_ready;
  assign want = match && !drop_x0;
  // Pop in the same cycle frees the slot for a push into a full FIFO.
  assign ovf  = want && full && !pop;
  assign push = want && !ovf;

  assign bus.wb_valid = count_q != '0;
  assign bus.wb_data  = bus.wb_valid ? dat_mem[head_q] : '0;
  assign bus.wb_tag   = bus.wb_valid ? tag_mem[head_q] : '0;
  assign count        = count_q;
  assign err          = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tok_q <= '0;
      for (int i = 0; i < LAT; i++)
        tag_q[i] <= '0;
    end else begin
      tok_q[0] <= accept;
      tag_q[0] <= bus.issue_tag;
      for (int i = 1; i < LAT; i++) begin
        tok_q[i] <= tok_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)
        count_q <= count_q + CW'(1);
      else if (pop && !push)
        count_q <= count_q - CW'(1);
      if (mismatch || ovf) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated by wb_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      dat_mem[tail_q] <= bus.cvt_y;
      tag_mem[tail_q] <= tag_out;
    end
  end
endmodule
